rotator: RTL and testbench

ROTATOR -- requirements
Module: rotator

---
 rtl/rotator.sv | 72 +++++++
 tb/tb_rotator.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rotator.sv
// Rotating selector: presents the data vector rotated right by a pointer
// held in a register. The pointer can be loaded or advanced by one. It
// always stays in 0..WIDTH-1, including for non-power-of-two widths.
module rotator #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned PW = (WIDTH <= 2) ? 1 : $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic             en,
    input  logic             load,
    input  logic [PW-1:0]    load_val,
    output logic [WIDTH-1:0] z,
    output logic [PW-1:0]    ptr
);

    // Highest legal pointer value. The advance step wraps from here back to zero.
    localparam logic [PW-1:0] PTR_LAST  = PW'(WIDTH - 1);
    localparam logic [PW:0]   WIDTH_EXT = (PW + 1)'(WIDTH);

    // Reduce a PW-bit value modulo WIDTH.
    // Because 2**PW < 2*WIDTH, at most one subtraction is ever needed.
    function automatic logic [PW-1:0] mod_width(input logic [PW-1:0] val);
        logic [PW:0] ext;
        ext = {1'b0, val};
        if (ext >= WIDTH_EXT) begin
            mod_width = PW'(ext - WIDTH_EXT);
        end else begin
            mod_width = val;
        end
    endfunction

    logic [PW-1:0]      ptr_q;
    logic [PW-1:0]      ptr_d;
    logic [2*WIDTH-1:0] dbl_s;

    // Next pointer. Load wins over advance, and advance wraps at WIDTH-1.
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = mod_width(load_val);
        end else if (en) begin
            if (ptr_q == PTR_LAST) begin
                ptr_d = {PW{1'b0}};
            end else begin
                ptr_d = ptr_q + PW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register. The reset is asynchronous, so the pointer clears without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= {PW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Rotate right by ptr: bit i of {x,x} >> ptr is x[(i+ptr) mod WIDTH].
    // Each output bit comes from exactly one input bit, so an X on x stays in its own lane.
    always_comb begin
        dbl_s = {x, x} >> ptr_q;
        z     = dbl_s[WIDTH-1:0];
    end

    assign ptr = ptr_q;

endmodule

// File: tb/tb_rotator.sv
// Directed testbench for rotator. Two instances are used: WIDTH=4 and WIDTH=5, the second being a non-power-of-two width.
module tb_rotator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] x4;
    logic       en4, load4;
    logic [1:0] lv4;
    logic [3:0] z4;
    logic [1:0] p4;
    logic [4:0] x5;
    logic       en5, load5;
    logic [2:0] lv5;
    logic [4:0] z5;
    logic [2:0] p5;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rotator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .x(x4), .en(en4), .load(load4),
        .load_val(lv4), .z(z4), .ptr(p4)
    );

    rotator #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .x(x5), .en(en5), .load(load5),
        .load_val(lv5), .z(z5), .ptr(p5)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rotation: z[i] = x[(i+p) mod w]
    function automatic logic [63:0] rot_model(input logic [63:0] xv, input int w, input int p);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < w; i++) r[i] = xv[(i + p) % w];
        return r;
    endfunction

    initial begin
        int unsigned exp5;
        rst_n = 1'b0;
        x4 = 4'b0010; en4 = 1'b0; load4 = 1'b0; lv4 = 2'd0;
        x5 = 5'b00000; en5 = 1'b0; load5 = 1'b0; lv5 = 3'd0;

        // Reset held: ptr is 0 and z follows x.
        #1;
        check("rst_ptr4", p4, 64'd0);
        check("rst_z4_0010", z4, 64'b0010);
        x4 = 4'b0111; #1;
        check("rst_z4_0111", z4, 64'b0111);
        x4 = 4'b1000; #1;
        check("rst_z4_1000", z4, 64'b1000);
        check("rst_ptr5", p5, 64'd0);

        // en and load are ignored while reset is held.
        en4 = 1'b1; load4 = 1'b1; lv4 = 2'd3;
        @(posedge clk); #1;
        check("rst_ign_ptr4", p4, 64'd0);
        check("rst_ign_z4", z4, 64'b1000);

        @(negedge clk);
        rst_n = 1'b1; en4 = 1'b0; load4 = 1'b0;

        // A single advance step.
        @(negedge clk); en4 = 1'b1;
        @(posedge clk); #1;
        check("en_ptr1", p4, 64'd1);
        @(negedge clk); en4 = 1'b0;
        x4 = 4'b0010; #1;
        check("p1_z_0010", z4, 64'b0001);
        x4 = 4'b1000; #1;
        check("p1_z_1000", z4, 64'b0100);
        @(posedge clk); #1;
        check("hold_ptr1", p4, 64'd1);

        // Load 3, then advance so the pointer wraps to 0.
        @(negedge clk); load4 = 1'b1; lv4 = 2'd3; x4 = 4'b0111;
        @(posedge clk); #1;
        check("load3_ptr", p4, 64'd3);
        check("load3_z", z4, 64'b1110);
        @(negedge clk); load4 = 1'b0; en4 = 1'b1;
        @(posedge clk); #1;
        check("wrap_ptr", p4, 64'd0);
        check("wrap_z", z4, 64'b0111);

        // load and en together: the load wins.
        @(negedge clk); load4 = 1'b1; en4 = 1'b1; lv4 = 2'd2; x4 = 4'b0001;
        @(posedge clk); #1;
        check("prio_ptr", p4, 64'd2);
        check("prio_z", z4, 64'b0100);
        @(negedge clk); load4 = 1'b0; en4 = 1'b0;

        // Reset asserted between edges clears the pointer immediately.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ptr", p4, 64'd0);
        check("async_rst_z", z4, 64'b0001);
        en4 = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("release_en", p4, 64'd1);
        @(negedge clk); en4 = 1'b0;

        // WIDTH=5: advance five times and expect 1,2,3,4,0.
        x5 = 5'b00001;
        en5 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("w5_seq%0d", k), p5, 64'(k % 5));
            if (k == 4) check("w5_p4_z", z5, 64'b00010);
        end
        @(negedge clk); en5 = 1'b0;

        // WIDTH=5: load values of WIDTH and above are reduced mod 5.
        load5 = 1'b1; lv5 = 3'd7;
        @(posedge clk); #1;
        check("w5_load7", p5, 64'd2);
        @(negedge clk); lv5 = 3'd5;
        @(posedge clk); #1;
        check("w5_load5", p5, 64'd0);
        @(negedge clk); lv5 = 3'd4;
        @(posedge clk); #1;
        check("w5_load4", p5, 64'd4);
        @(negedge clk); load5 = 1'b0;

        // Random sweep over pointer values and data.
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            load4 = 1'b1; lv4 = 2'($urandom_range(0, 3));
            load5 = 1'b1; lv5 = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            exp5 = 32'(lv5) % 5;
            check("rnd_ptr4", p4, 64'(lv4));
            check("rnd_ptr5", p5, 64'(exp5));
            x4 = 4'($urandom_range(0, 15));
            x5 = 5'($urandom_range(0, 31));
            #1;
            check("rnd_z4", z4, rot_model(64'(x4), 4, int'(lv4)));
            check("rnd_z5", z5, rot_model(64'(x5), 5, int'(exp5)));
            check("rnd_pop4", 64'($countones(z4)), 64'($countones(x4)));
            check("rnd_pop5", 64'($countones(z5)), 64'($countones(x5)));
        end
        @(negedge clk); load4 = 1'b0; load5 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
